// File: rtl/voice_allocator_if.sv
// MIDI message handshake bundle for the voice allocator.
// A full 3-byte message moves on midi_valid && midi_ready.
interface voice_allocator_if;
    logic       midi_valid;
    logic [7:0] midi_byte0;
    logic [7:0] midi_byte1;
    logic [7:0] midi_byte2;
    logic       midi_ready;

    modport master (
        output midi_valid,
        output midi_byte0,
        output midi_byte1,
        output midi_byte2,
        input  midi_ready
    );

    modport slave (
        input  midi_valid,
        input  midi_byte0,
        input  midi_byte1,
        input  midi_byte2,
        output midi_ready
    );
endinterface

// File: rtl/voice_allocator.sv
// Voice allocator: MIDI note-on/off messages to polyphonic DDS voice slots.
// Define VOICE_STEAL_EN to steal voices round-robin when all are gated.
module voice_allocator #(
    parameter int POLYPHONY = 8,
    parameter int FREQ_W    = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    voice_allocator_if.slave            midi,
    output logic [6:0]                  lookup_note,
    input  logic [FREQ_W-1:0]           lookup_code,
    output logic [POLYPHONY*FREQ_W-1:0] dds_frequency_concat,
    output logic [POLYPHONY*7-1:0]      voice_note_concat,
    output logic [POLYPHONY-1:0]        key_state,
    output logic                        note_dropped
);
    localparam int PW = (POLYPHONY > 1) ? $clog2(POLYPHONY) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DECODE = 2'd1;
    localparam logic [1:0] UPDATE = 2'd2;

    logic [1:0]        r_state;
    logic [7:0]        r_b0;
    logic [7:0]        r_b1;
    logic [7:0]        r_b2;
    logic [FREQ_W-1:0] r_freq [POLYPHONY];
    logic [6:0]        r_note [POLYPHONY];
    logic [POLYPHONY-1:0] r_key;
    logic              r_dropped;

    logic                 w_accept;
    logic                 w_is_on;
    logic                 w_is_off;
    logic [6:0]           w_note;
    logic [POLYPHONY-1:0] w_match;
    logic                 w_any_match;
    logic                 w_any_free;
    logic [PW-1:0]        w_match_idx;
    logic [PW-1:0]        w_free_idx;
    logic                 w_steal;
    logic                 w_unused;

    assign midi.midi_ready = (r_state == IDLE) && !reset;
    assign w_accept = midi.midi_valid && midi.midi_ready;

    // Channel nibble and note bit 7 carry no meaning here.
    assign w_unused = ^{r_b0[3:0], r_b1[7]};

    assign w_note   = r_b1[6:0];
    assign w_is_on  = (r_b0[7:4] == 4'h9) && (r_b2 != 8'd0);
    assign w_is_off = (r_b0[7:4] == 4'h8) ||
                      ((r_b0[7:4] == 4'h9) && (r_b2 == 8'd0));

    always_comb begin
        w_match     = '0;
        w_any_match = 1'b0;
        w_any_free  = 1'b0;
        w_match_idx = '0;
        w_free_idx  = '0;
        for (int i = POLYPHONY - 1; i >= 0; i--) begin
            w_match[i] = r_key[i] && (r_note[i] == w_note);
            if (w_match[i]) begin
                w_any_match = 1'b1;
                w_match_idx = PW'(i);
            end
            if (!r_key[i]) begin
                w_any_free = 1'b1;
                w_free_idx = PW'(i);
            end
        end
    end

    assign w_steal = (r_state == DECODE) && w_is_on &&
                     !w_any_match && !w_any_free;

`ifdef VOICE_STEAL_EN
    logic [PW-1:0] r_steal;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_steal <= '0;
        end else if (w_steal) begin
            if (r_steal == PW'(POLYPHONY - 1))
                r_steal <= '0;
            else
                r_steal <= r_steal + 1'b1;
        end
    end
`endif

    // Voice writes land on the DECODE->UPDATE edge, using the live lookup.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_b0      <= '0;
            r_b1      <= '0;
            r_b2      <= '0;
            r_key     <= '0;
            r_dropped <= 1'b0;
            for (int i = 0; i < POLYPHONY; i++) begin
                r_freq[i] <= '0;
                r_note[i] <= '0;
            end
        end else begin
            r_dropped <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_b0    <= midi.midi_byte0;
                        r_b1    <= midi.midi_byte1;
                        r_b2    <= midi.midi_byte2;
                        r_state <= DECODE;
                    end
                end
                DECODE: begin
                    r_state <= UPDATE;
                    if (w_is_on) begin
                        if (w_any_match) begin
                            r_freq[w_match_idx] <= lookup_code;
                        end else if (w_any_free) begin
                            r_freq[w_free_idx] <= lookup_code;
                            r_note[w_free_idx] <= w_note;
                            r_key[w_free_idx]  <= 1'b1;
                        end else begin
`ifdef VOICE_STEAL_EN
                            r_freq[r_steal] <= lookup_code;
                            r_note[r_steal] <= w_note;
                            r_key[r_steal]  <= 1'b1;
`else
                            r_dropped <= w_steal;
`endif
                        end
                    end else if (w_is_off) begin
                        r_key <= r_key & ~w_match;
                    end
                end
                UPDATE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign lookup_note  = ((r_state == DECODE) && !reset) ? w_note : 7'd0;
    assign note_dropped = r_dropped && !reset;
    assign key_state    = reset ? '0 : r_key;

    for (genvar g = 0; g < POLYPHONY; g++) begin : g_pack
        assign dds_frequency_concat[g*FREQ_W +: FREQ_W] =
            reset ? '0 : r_freq[g];
        assign voice_note_concat[g*7 +: 7] =
            reset ? 7'd0 : r_note[g];
    end
endmodule

// File: tb/tb_voice_allocator.sv
// Randomized and directed bench for voice_allocator against a voice-table model.
// Model follows either build of VOICE_STEAL_EN.
module tb_voice_allocator;
    localparam int NV = 4;
    localparam int FW = 32;
    localparam int VW = NV*FW + NV*7 + NV;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    voice_allocator_if midi();

    logic [6:0]       lookup_note;
    logic [FW-1:0]    lookup_code;
    logic [NV*FW-1:0] dds;
    logic [NV*7-1:0]  vnotes;
    logic [NV-1:0]    key;
    logic             dropped;
    logic [VW-1:0]    act;

    logic [FW-1:0] tune [128];
    assign lookup_code = tune[lookup_note];
    assign act = {dds, vnotes, key};

    voice_allocator #(.POLYPHONY(NV), .FREQ_W(FW)) dut (
        .clk                  (clk),
        .reset                (reset),
        .midi                 (midi),
        .lookup_note          (lookup_note),
        .lookup_code          (lookup_code),
        .dds_frequency_concat (dds),
        .voice_note_concat    (vnotes),
        .key_state            (key),
        .note_dropped         (dropped)
    );

    int errors = 0;
    int checks = 0;

    logic [FW-1:0] m_freq [NV];
    logic [6:0]    m_note [NV];
    logic          m_key  [NV];
    int            m_ptr;

    function automatic void model_reset();
        for (int i = 0; i < NV; i++) begin
            m_freq[i] = '0;
            m_note[i] = '0;
            m_key[i]  = 1'b0;
        end
        m_ptr = 0;
    endfunction

    // Applies one message to the voice table; returns 1 if a note-on is discarded.
    function automatic logic model_msg(input logic [7:0] b0, b1, b2);
        logic [6:0] n;
        logic on;
        logic off;
        int hit;
        int fr;
        n   = b1[6:0];
        on  = (b0[7:4] == 4'h9) && (b2 != 8'd0);
        off = (b0[7:4] == 4'h8) || ((b0[7:4] == 4'h9) && (b2 == 8'd0));
        hit = -1;
        fr  = -1;
        for (int i = 0; i < NV; i++) begin
            if (hit < 0 && m_key[i] && m_note[i] == n) hit = i;
            if (fr < 0 && !m_key[i]) fr = i;
        end
        if (on) begin
            if (hit >= 0) begin
                m_freq[hit] = tune[n];
            end else if (fr >= 0) begin
                m_freq[fr] = tune[n];
                m_note[fr] = n;
                m_key[fr]  = 1'b1;
            end else begin
`ifdef VOICE_STEAL_EN
                m_freq[m_ptr] = tune[n];
                m_note[m_ptr] = n;
                m_key[m_ptr]  = 1'b1;
                m_ptr = (m_ptr + 1) % NV;
`else
                return 1'b1;
`endif
            end
        end else if (off) begin
            for (int i = 0; i < NV; i++)
                if (m_key[i] && m_note[i] == n) m_key[i] = 1'b0;
        end
        return 1'b0;
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic [NV*FW-1:0] f;
        logic [NV*7-1:0]  n;
        logic [NV-1:0]    k;
        for (int i = 0; i < NV; i++) begin
            f[i*FW +: FW] = m_freq[i];
            n[i*7 +: 7]   = m_note[i];
            k[i]          = m_key[i];
        end
        return {f, n, k};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    // Drives one message; returns just after the edge that ends DECODE.
    task automatic send(input logic [7:0] b0, b1, b2,
                        output logic [6:0] ln,
                        output logic [VW-1:0] snap,
                        output logic rdy_dec);
        int n;
        n = 0;
        while (midi.midi_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL ready_wait got=%b want=1", midi.midi_ready);
        end
        midi.midi_valid = 1'b1;
        midi.midi_byte0 = b0;
        midi.midi_byte1 = b1;
        midi.midi_byte2 = b2;
        tick();
        midi.midi_valid = 1'b0;
        ln      = lookup_note;
        snap    = act;
        rdy_dec = midi.midi_ready;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        midi.midi_valid = 1'b1;
        midi.midi_byte0 = 8'h90;
        midi.midi_byte1 = 8'd60;
        midi.midi_byte2 = 8'd100;
        repeat (3) tick();
        checks++;
        if (midi.midi_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_ready got=%b want=0", midi.midi_ready);
        end
        checks++;
        if (act !== '0) begin
            errors++;
            $display("FAIL rst_outputs got=%h want=0", act);
        end
        checks++;
        if (lookup_note !== 7'd0 || dropped !== 1'b0) begin
            errors++;
            $display("FAIL rst_misc got=%h/%b want=0/0", lookup_note, dropped);
        end
        midi.midi_valid = 1'b0;
        reset = 1'b0;
        #1;
        checks++;
        if (midi.midi_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_release_ready got=%b want=1", midi.midi_ready);
        end
        model_reset();
    endtask

    task automatic test_basic();
        logic [6:0] ln;
        logic [VW-1:0] snap;
        logic rd;
        do_reset();
        tune[60] = 32'h1234;
        send(8'h90, 8'd60, 8'd100, ln, snap, rd);
        checks++;
        if (ln !== 7'd60 || rd !== 1'b0 || snap !== '0) begin
            errors++;
            $display("FAIL basic_decode got=%0d/%b/%h want=60/0/0", ln, rd, snap);
        end
        checks++;
        if (dds[FW-1:0] !== 32'h1234 || vnotes[6:0] !== 7'd60 || key !== 4'b0001) begin
            errors++;
            $display("FAIL basic_voice0 got=%h/%0d/%b want=1234/60/0001",
                     dds[FW-1:0], vnotes[6:0], key);
        end
        checks++;
        if (midi.midi_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy got=%b want=0", midi.midi_ready);
        end
        tick();
        checks++;
        if (midi.midi_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_ready3 got=%b want=1", midi.midi_ready);
        end
        void'(model_msg(8'h90, 8'd60, 8'd100));
    endtask

    task automatic test_note_off();
        logic [6:0] ln;
        logic [VW-1:0] snap;
        logic rd;
        do_reset();
        send(8'h90, 8'd60, 8'd90, ln, snap, rd);
        send(8'h91, 8'd62, 8'd90, ln, snap, rd);
        send(8'h92, 8'd64, 8'd90, ln, snap, rd);
        send(8'h80, 8'd62, 8'd40, ln, snap, rd);
        checks++;
        if (key !== 4'b0101 || dds[2*FW-1:FW] !== tune[62] || vnotes[13:7] !== 7'd62) begin
            errors++;
            $display("FAIL off_release got=%b/%h want=0101/%h", key, dds[2*FW-1:FW], tune[62]);
        end
        send(8'h90, 8'd65, 8'd90, ln, snap, rd);
        checks++;
        if (key !== 4'b0111 || vnotes[13:7] !== 7'd65 || dds[2*FW-1:FW] !== tune[65]) begin
            errors++;
            $display("FAIL off_realloc got=%b/%0d want=0111/65", key, vnotes[13:7]);
        end
        send(8'h90, 8'd64, 8'd0, ln, snap, rd);
        checks++;
        if (key !== 4'b0011) begin
            errors++;
            $display("FAIL vel0_release got=%b want=0011", key);
        end
        send(8'h90, 8'd64, 8'd70, ln, snap, rd);
        tune[64] = tune[64] ^ 32'h00FF_0F0F;
        send(8'h90, 8'd64, 8'd70, ln, snap, rd);
        checks++;
        if (key !== 4'b0111 || dds[3*FW-1:2*FW] !== tune[64] || vnotes[20:14] !== 7'd64) begin
            errors++;
            $display("FAIL retrigger got=%b/%h want=0111/%h", key, dds[3*FW-1:2*FW], tune[64]);
        end
        model_reset();
        void'(model_msg(8'h90, 8'd60, 8'd1));
        void'(model_msg(8'h90, 8'd65, 8'd1));
        void'(model_msg(8'h90, 8'd64, 8'd1));
        checks++;
        if (act !== exp_vec()) begin
            errors++;
            $display("FAIL off_model got=%h want=%h", act, exp_vec());
        end
    endtask

    task automatic test_full();
        logic [6:0] ln;
        logic [VW-1:0] snap;
        logic [VW-1:0] pre;
        logic rd;
        logic ed;
        do_reset();
        for (int n = 60; n < 64; n++) begin
            send(8'h90, 8'(n), 8'd100, ln, snap, rd);
            void'(model_msg(8'h90, 8'(n), 8'd100));
        end
        pre = act;
        send(8'h90, 8'd64, 8'd100, ln, snap, rd);
        ed = model_msg(8'h90, 8'd64, 8'd100);
        checks++;
        if (dropped !== ed) begin
            errors++;
            $display("FAIL full_drop got=%b want=%b", dropped, ed);
        end
        checks++;
        if (act !== exp_vec()) begin
            errors++;
            $display("FAIL full_voices got=%h want=%h pre=%h", act, exp_vec(), pre);
        end
        tick();
        checks++;
        if (dropped !== 1'b0) begin
            errors++;
            $display("FAIL full_pulse got=%b want=0", dropped);
        end
        send(8'h90, 8'd65, 8'd100, ln, snap, rd);
        ed = model_msg(8'h90, 8'd65, 8'd100);
        checks++;
        if (act !== exp_vec() || dropped !== ed) begin
            errors++;
            $display("FAIL full_sixth got=%h/%b want=%h/%b", act, dropped, exp_vec(), ed);
        end
    endtask

    task automatic test_cc_and_reset_mid();
        logic [6:0] ln;
        logic [VW-1:0] snap;
        logic [VW-1:0] pre;
        logic rd;
        pre = act;
        send(8'hB0, 8'd7, 8'd100, ln, snap, rd);
        checks++;
        if (act !== pre || rd !== 1'b0 || midi.midi_ready !== 1'b0 || dropped !== 1'b0) begin
            errors++;
            $display("FAIL cc_noop got=%h/%b want=%h/0", act, midi.midi_ready, pre);
        end
        tick();
        checks++;
        if (midi.midi_ready !== 1'b1) begin
            errors++;
            $display("FAIL cc_ready got=%b want=1", midi.midi_ready);
        end
        do_reset();
        midi.midi_valid = 1'b1;
        midi.midi_byte0 = 8'h90;
        midi.midi_byte1 = 8'd70;
        midi.midi_byte2 = 8'd100;
        tick();
        midi.midi_valid = 1'b0;
        reset = 1'b1;
        tick();
        checks++;
        if (act !== '0 || midi.midi_ready !== 1'b0 || lookup_note !== 7'd0) begin
            errors++;
            $display("FAIL midrst_outputs got=%h/%b want=0/0", act, midi.midi_ready);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (midi.midi_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_ready got=%b want=1", midi.midi_ready);
        end
        repeat (3) tick();
        checks++;
        if (act !== '0) begin
            errors++;
            $display("FAIL midrst_nowrite got=%h want=0", act);
        end
        model_reset();
    endtask

    task automatic test_random();
        logic [6:0] ln;
        logic [VW-1:0] snap;
        logic [VW-1:0] pre;
        logic rd;
        logic ed;
        logic [7:0] st [6];
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        st[0] = 8'h80; st[1] = 8'h90; st[2] = 8'h90;
        st[3] = 8'hB0; st[4] = 8'hC0; st[5] = 8'h90;
        do_reset();
        for (int k = 0; k < 150; k++) begin
            b0 = st[$urandom_range(0, 5)] | 8'($urandom_range(0, 15));
            b1 = 8'(56 + $urandom_range(0, 7)) | (8'($urandom_range(0, 1)) << 7);
            b2 = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 127));
            if ($urandom_range(0, 7) == 0) tune[b1[6:0]] = $urandom;
            pre = exp_vec();
            send(b0, b1, b2, ln, snap, rd);
            ed = model_msg(b0, b1, b2);
            checks++;
            if (ln !== b1[6:0] || snap !== pre || rd !== 1'b0) begin
                errors++;
                $display("FAIL rnd_decode k=%0d got=%0d/%b want=%0d/0", k, ln, rd, b1[6:0]);
            end
            checks++;
            if (act !== exp_vec() || dropped !== ed) begin
                errors++;
                $display("FAIL rnd_update k=%0d msg=%h%h%h got=%h/%b want=%h/%b",
                         k, b0, b1, b2, act, dropped, exp_vec(), ed);
            end
            tick();
            checks++;
            if (midi.midi_ready !== 1'b1 || dropped !== 1'b0) begin
                errors++;
                $display("FAIL rnd_idle k=%0d got=%b/%b want=1/0", k, midi.midi_ready, dropped);
            end
        end
    endtask

    initial begin
        midi.midi_valid = 1'b0;
        midi.midi_byte0 = '0;
        midi.midi_byte1 = '0;
        midi.midi_byte2 = '0;
        for (int i = 0; i < 128; i++) tune[i] = $urandom;
        model_reset();
        test_reset();
        test_basic();
        test_note_off();
        test_full();
        test_cc_and_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 SHALL have parameter POLYPHONY, default 8, the number of voices (2..16).
REQ-002 SHALL have parameter FREQ_W, default 32, the width of each voice's DDS tuning word.
REQ-003 SHALL have port clk  input  1  system clock, all logic on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port midi_valid  input  1  a complete 3-byte MIDI message is present.
REQ-006 SHALL have port midi_byte0 / midi_byte1 / midi_byte2  input  8 each  status, note, velocity.
REQ-007 SHALL have port midi_ready  output  1  the block can accept a message this cycle.
REQ-008 SHALL have port lookup_note  output  7  note number driven to the external combinational tuning table.
REQ-009 SHALL have port lookup_code  input  FREQ_W  tuning word for lookup_note, valid in the same cycle.
REQ-010 SHALL have port dds_frequency_concat  output  POLYPHONY*FREQ_W  tuning words, voice 0 in the LSBs.
REQ-011 SHALL have port voice_note_concat  output  POLYPHONY*7  held note per voice, voice 0 in the LSBs.
REQ-012 SHALL have port key_state  output  POLYPHONY  1 = voice gated on (ADSR key).
REQ-013 SHALL have port note_dropped  output  1  single-cycle pulse when a note-on is discarded.

Function
REQ-014 SHALL use FSM states IDLE, DECODE, UPDATE; IDLE->DECODE on accept, DECODE->UPDATE always, UPDATE->IDLE always.
REQ-015 SHALL drive midi_ready=1 only in IDLE; a message is accepted when midi_valid && midi_ready, and byte0..2 are latched on accept.
REQ-016 SHALL drive lookup_note = latched byte1[6:0] in DECODE and sample lookup_code in DECODE.
REQ-017 SHALL make output changes visible 2 cycles after the accept edge; midi_ready SHALL return to 1 3 cycles after accept.
REQ-018 SHALL classify status[7:4]=0x9 with velocity!=0 as note-on; 0x8, or 0x9 with velocity=0, as note-off; anything else is ignored (state walk only, no output change); the channel nibble is ignored.
REQ-019 Note-on retrigger: if any voice has key_state=1 and voice_note=note, the lowest such voice SHALL be reloaded with lookup_code and stay gated on; no new voice is allocated.
REQ-020 Note-on allocation: otherwise the lowest-index voice with key_state=0 SHALL get frequency=lookup_code, voice_note=note, key_state=1.
REQ-021 Note-on full: if all voices are gated, the outcome SHALL follow REQ-027/REQ-028.
REQ-022 Note-off SHALL clear key_state of every voice whose key_state=1 and voice_note=note, leaving its frequency and voice_note unchanged (release phase); a note-off with no match SHALL be a no-op.
REQ-023 The steal pointer SHALL be log2-width, wrap from POLYPHONY-1 to 0, and advance only on a steal.
REQ-024 voice_note SHALL be 7 bits; note byte bit 7 SHALL be ignored.

Reset
REQ-025 While reset=1: FSM=IDLE, midi_ready=0, all key_state=0, all dds_frequency=0, all voice_note=0, steal pointer=0, note_dropped=0, lookup_note=0.
REQ-026 Reset asserted mid-message SHALL abort the message with no output update; midi_ready=1 in the first cycle after reset falls.

Configuration
REQ-027 With VOICE_STEAL_EN defined, a note-on with all voices gated SHALL overwrite the voice at the steal pointer (frequency, note, key_state=1), advance the pointer, and leave note_dropped=0.
REQ-028 Without VOICE_STEAL_EN, that note-on SHALL be discarded, note_dropped SHALL pulse high for one cycle in UPDATE, no voice SHALL change, and the steal pointer logic SHALL be absent.

Verification
REQ-029 Reset, then note-on 0x90,60,100 with lookup_code=0x1234 -> voice0 freq=0x1234, note=60, key_state=0x01 exactly 2 cycles after accept; midi_ready high 3 cycles after accept.
REQ-030 Note-ons 60,62,64, then note-off 0x80,62 -> key_state=0b101, voice1 freq retained; a following note-on 65 lands in voice1.
REQ-031 Note-on 0x90,64,0 after note 64 is held -> its voice is released; a second note-on 64 while held -> same voice reloaded, no new allocation.
REQ-032 POLYPHONY=4: five note-ons 60..64 -> with VOICE_STEAL_EN voice0 holds 64 and the pointer is 1 (a sixth note-on goes to voice1); without it note_dropped pulses once and the voices are unchanged.
REQ-033 Control change 0xB0,7,100 -> no output change, 3-cycle busy; reset asserted in DECODE of a note-on -> all outputs 0, no voice written.
